// File: rtl/data_plane_rx_fifo.sv
// Data-plane receiver: destination-ID filter, in-order payload FIFO,
// burst counting with idle timeout, and sticky clearable error flags.
module data_plane_rx_fifo #(
  parameter int DATA_W      = 16,
  parameter int ID_W        = 16,
  parameter int DEPTH       = 16,
  parameter int BURST_LEN   = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          node_id,
  input  logic [ID_W+DATA_W-1:0]   rx_packet,
  input  logic                     rx_valid,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     burst_done,
  output logic                     overflow,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [IW-1:0]     idle, idle_n;
  logic              done_n;
  logic              abort;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  logic match, full, empty, push, pop, drop;

  assign match = rx_valid &&
                 (rx_packet[ID_W+DATA_W-1:DATA_W] == node_id);
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  // A pop frees the slot this cycle, so a full FIFO still accepts a push.
  assign pop   = rd_en && !empty;
  assign push  = match && (!full || pop);
  assign drop  = match && full && !pop;

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_packet[DATA_W-1:0];
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Burst state, packet count, idle counter and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      idle       <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      idle       <= idle_n;
      burst_done <= done_n;
    end
  end

  // Next burst state; dropped packets still count toward the burst.
  always_comb begin
    state_n = state;
    count_n = count;
    idle_n  = idle;
    done_n  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        idle_n = '0;
        if (match) begin
          if (BURST_LEN == 1) begin
            done_n = 1'b1;
          end else begin
            count_n = CW'(1);
            state_n = BURST;
          end
        end
      end
      BURST: begin
        if (match) begin
          idle_n = '0;
          if (count == CW'(BURST_LEN - 1)) begin
            count_n = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            count_n = count + 1'b1;
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (idle == IW'(TIMEOUT_CYC - 1)) begin
            abort   = 1'b1;
            count_n = '0;
            idle_n  = '0;
            state_n = IDLE;
          end else begin
            idle_n = idle + 1'b1;
          end
        end
      end
    endcase
  end

  // Sticky error flags; a set event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (abort)        timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: doc/data_plane_rx_fifo.md
Name: data_plane_rx_fifo

Overview:
- Parametrised next-generation data-plane receiver for a photonic-interconnect node.
- Filters incoming data-plane packets by destination ID and buffers matching payloads in an in-order FIFO.
- Counts packets into fixed-length bursts, signals burst completion to the control plane, and serves buffered words to the GPP through a read handshake.
- Adds overflow and burst-timeout detection with sticky, clearable error flags.

Parameters:
- DATA_W, 16: payload width; packet bits [DATA_W-1:0].
- ID_W, 16: destination ID width; packet bits [ID_W+DATA_W-1:DATA_W].
- DEPTH, 16: FIFO entries; power of 2, at least 2.
- BURST_LEN, 5: matching packets per burst; at least 1.
- TIMEOUT_CYC, 64: idle cycles allowed inside a burst before abort; 0 disables the timeout.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- node_id, input, ID_W: this node's ID; quasi-static.
- rx_packet, input, ID_W+DATA_W: incoming data-plane packet.
- rx_valid, input, 1: rx_packet is valid this cycle.
- rd_en, input, 1: GPP read request; pops one word.
- rd_data, output, DATA_W: popped word, registered.
- rd_valid, output, 1: rd_data is valid; 1-cycle pulse.
- level, output, $clog2(DEPTH)+1: current FIFO occupancy.
- burst_done, output, 1: 1-cycle pulse when a burst completes.
- overflow, output, 1: sticky; a matching packet was dropped because the FIFO was full.
- timeout_err, output, 1: sticky; a burst was aborted by timeout.
- err_clr, input, 1: synchronous clear of overflow and timeout_err.

Behaviour:
- Reset (asynchronous, any time including mid-burst):
  - level=0, rd_data=0, rd_valid=0, burst_done=0, overflow=0, timeout_err=0.
  - Write and read pointers = 0; burst count = 0; idle counter = 0; state = IDLE.
  - FIFO contents are don't-care after reset.
- Match: match = rx_valid && (rx_packet[ID_W+DATA_W-1:DATA_W] == node_id).
  - Non-matching packets and packets with rx_valid=0 are ignored entirely.
- Write:
  - On a match with the FIFO not full, the payload is stored at the write pointer at the edge, and the write pointer increments.
  - Pointers wrap modulo DEPTH.
- Drop:
  - On a match with the FIFO full and no same-cycle pop, the payload is discarded and overflow is set at the edge.
  - The dropped packet still counts toward the burst.
- Read:
  - rd_en with level>0 pops the head word. rd_data is updated and rd_valid=1 in the following cycle; latency is 1.
  - rd_en with level=0 is ignored: rd_valid=0 and rd_data holds its value.
- Simultaneous write and read:
  - Full with push and pop: both are accepted, level is unchanged, and no overflow.
  - Empty with push and pop: the pop is ignored (no fall-through), the push is accepted, and level becomes 1.
- Level: level(next) = level + push_accepted - pop_accepted. It never exceeds DEPTH and never underflows.
- Burst state machine (count is 0..BURST_LEN-1):
  - IDLE (count=0): a match with BURST_LEN>1 sets count=1 and moves to BURST. A match with BURST_LEN=1 pulses burst_done and stays in IDLE.
  - BURST, on a match: count increments. If count==BURST_LEN-1 at the match, count goes to 0, burst_done=1 in the next cycle, and the state returns to IDLE.
  - BURST, with no match: the idle counter increments. When it reaches TIMEOUT_CYC (if TIMEOUT_CYC≠0), count goes to 0, timeout_err is set, and the state returns to IDLE.
  - Data already buffered from an aborted burst is retained.
  - Every match resets the idle counter to 0.
- burst_done is exactly one cycle wide. Back-to-back bursts give separate pulses, at least BURST_LEN cycles apart.
- Error flags:
  - err_clr clears both flags at the edge.
  - If a set event and err_clr occur in the same cycle, the set wins.

Test Plan:
1. node_id=0x0003; 5 matching packets on consecutive cycles with payloads 0x0A..0x0E -> level=5, one burst_done pulse in the cycle after the 5th packet; reads return 0x0A,0x0B,0x0C,0x0D,0x0E in order, each with rd_valid=1.
2. Interleave packets with IDs 0x0003 and 0x0007, plus packets with rx_valid=0 -> only the ID 0x0003 payloads are stored; the other IDs and invalid cycles leave level and burst count unchanged.
3. DEPTH=16: 17 matching packets with no reads -> level=16, overflow=1 after the 17th; pulse err_clr -> overflow=0. With level=16, push plus rd_en in the same cycle -> level stays 16, overflow stays 0.
4. TIMEOUT_CYC=64: 2 matching packets, then 64 idle cycles -> timeout_err=1, burst count reset, level=2. The next 5 matches produce exactly one burst_done.
5. Empty FIFO: rd_en alone -> rd_valid=0. Push plus rd_en in the same cycle -> level=1 and rd_valid=0 in the following cycle.
6. Assert rst asynchronously (off a clock edge) mid-burst with level=3 -> all outputs drop to 0 immediately. After release, 5 matches produce exactly one burst_done.
